// File: rtl/wash_pkg.sv
// Shared constants for the wash plant model.
// Holds the default rate dividers, tub and temperature limits, output widths
// and the bit positions of the sticky fault flags. Imported by every file of
// the wash block so the numbers live in one place.
package wash_pkg;

  // Rate dividers: clock cycles per one-unit change of the plant quantity
  localparam int FILL_DIV_DEF  = 4;
  localparam int DRAIN_DIV_DEF = 2;
  localparam int HEAT_DIV_DEF  = 8;
  localparam int COOL_DIV_DEF  = 16;

  // Tub capacity and full-sensor threshold
  localparam int LEVEL_MAX_DEF  = 15;
  localparam int LEVEL_FULL_DEF = 12;

  // Resting, target and ceiling temperature
  localparam int AMBIENT_DEF  = 10;
  localparam int TEMP_SET_DEF = 14;
  localparam int TEMP_MAX_DEF = 63;

  // Output widths
  localparam int LEVEL_W = 8;
  localparam int TEMP_W  = 8;
  localparam int FAULT_W = 2;

  // Sticky fault bit positions
  localparam int FAULT_DRY_HEAT = 0;
  localparam int FAULT_OVERFLOW = 1;

endpackage

// File: rtl/wash_tick.sv
// Rate prescaler for one plant channel.
// Counts 0..DIV-1 while en is high and raises tick for one cycle when the
// count sits at DIV-1; the count wraps to 0 on that tick. Whenever en is low
// the count is cleared, so every enable run starts a fresh period and the
// first tick lands DIV cycles after en is first sampled high.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-low
//   en    - channel enable
//   tick  - one-cycle rate pulse (combinational from count and en)
module wash_tick
  import wash_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (!en || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/wash_plant.sv
// Behavioural plant model of a washing machine tub for controller testing.
// Tracks water level and water temperature, each moved at a fixed rate by a
// wash_tick prescaler, and reports registered sensor flags plus sticky faults.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-low
//   water_in - inlet valve command
//   heat_r   - heater command
//   wash     - drum command, no effect on the plant
//   drain    - drain pump command
//   speed    - spin command, doubles the drain step
//   full     - registered: level >= LEVEL_FULL
//   empty    - registered: level == 0
//   cold     - registered: temp < TEMP_SET
//   level    - current water level
//   temp     - current water temperature
//   fault    - sticky faults, bit0 dry heat, bit1 overflow
module wash_plant
  import wash_pkg::*;
#(
  parameter int FILL_DIV   = FILL_DIV_DEF,
  parameter int DRAIN_DIV  = DRAIN_DIV_DEF,
  parameter int HEAT_DIV   = HEAT_DIV_DEF,
  parameter int COOL_DIV   = COOL_DIV_DEF,
  parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int LEVEL_FULL = LEVEL_FULL_DEF,
  parameter int AMBIENT    = AMBIENT_DEF,
  parameter int TEMP_SET   = TEMP_SET_DEF,
  parameter int TEMP_MAX   = TEMP_MAX_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               water_in,
  input  logic               heat_r,
  input  logic               wash,
  input  logic               drain,
  input  logic               speed,
  output logic               full,
  output logic               empty,
  output logic               cold,
  output logic [LEVEL_W-1:0] level,
  output logic [TEMP_W-1:0]  temp,
  output logic [FAULT_W-1:0] fault
);

  // Arithmetic is done two bits wider and signed so a decrement below zero or
  // an increment past the ceiling is visible before it is clamped.
  localparam int SW = LEVEL_W + 2;

  localparam logic signed [SW-1:0] LEVEL_MAX_S = SW'(LEVEL_MAX);
  localparam logic signed [SW-1:0] AMBIENT_S   = SW'(AMBIENT);
  localparam logic signed [SW-1:0] TEMP_MAX_S  = SW'(TEMP_MAX);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX_U  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL_U = LEVEL_W'(LEVEL_FULL);
  localparam logic [TEMP_W-1:0]  AMBIENT_U    = TEMP_W'(AMBIENT);
  localparam logic [TEMP_W-1:0]  TEMP_SET_U   = TEMP_W'(TEMP_SET);

  function automatic logic [LEVEL_W-1:0] sat_level(input logic signed [SW-1:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > LEVEL_MAX_S) begin
      return LEVEL_MAX_U;
    end else begin
      return v[LEVEL_W-1:0];
    end
  endfunction

  // Cooling is only enabled above ambient, but the clamp keeps the floor
  // explicit should the divider or enable logic ever change.
  function automatic logic [TEMP_W-1:0] sat_temp(input logic signed [SW-1:0] v);
    if (v < AMBIENT_S) begin
      return AMBIENT_U;
    end else if (v > TEMP_MAX_S) begin
      return TEMP_W'(TEMP_MAX);
    end else begin
      return v[TEMP_W-1:0];
    end
  endfunction

  logic fill_en, drain_en, heat_en, cool_en;
  logic fill_tick, drain_tick, heat_tick, cool_tick;
  logic signed [SW-1:0] level_delta, temp_delta;
  logic [LEVEL_W-1:0] level_next;
  logic [TEMP_W-1:0]  temp_next;
  logic unused_wash;

  assign unused_wash = wash;

  // Opposing valve and pump commands cancel: neither channel runs, so both
  // prescalers clear and the level holds.
  assign fill_en  = water_in & ~drain;
  assign drain_en = drain & ~water_in;
  assign heat_en  = heat_r & (level != '0);
  assign cool_en  = ~heat_r & (temp > AMBIENT_U);

  wash_tick #(.DIV(FILL_DIV)) u_fill_tick (
    .clk   (clk),
    .reset (reset),
    .en    (fill_en),
    .tick  (fill_tick)
  );

  wash_tick #(.DIV(DRAIN_DIV)) u_drain_tick (
    .clk   (clk),
    .reset (reset),
    .en    (drain_en),
    .tick  (drain_tick)
  );

  wash_tick #(.DIV(HEAT_DIV)) u_heat_tick (
    .clk   (clk),
    .reset (reset),
    .en    (heat_en),
    .tick  (heat_tick)
  );

  wash_tick #(.DIV(COOL_DIV)) u_cool_tick (
    .clk   (clk),
    .reset (reset),
    .en    (cool_en),
    .tick  (cool_tick)
  );

  always_comb begin
    level_delta = '0;
    if (fill_tick) begin
      level_delta = SW'(1);
    end else if (drain_tick) begin
      level_delta = speed ? -SW'(2) : -SW'(1);
    end
  end

  always_comb begin
    temp_delta = '0;
    if (heat_tick) begin
      temp_delta = SW'(1);
    end else if (cool_tick) begin
      temp_delta = -SW'(1);
    end
  end

  assign level_next = sat_level(signed'({2'b00, level}) + level_delta);
  assign temp_next  = sat_temp(signed'({2'b00, temp}) + temp_delta);

  // Sensor flags are computed from the current register values, so they lag
  // a level/temp change by one cycle, like a real debounced sensor.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level <= '0;
      temp  <= AMBIENT_U;
      full  <= 1'b0;
      empty <= 1'b1;
      cold  <= 1'b1;
      fault <= '0;
    end else begin
      level <= level_next;
      temp  <= temp_next;
      full  <= (level >= LEVEL_FULL_U);
      empty <= (level == '0);
      cold  <= (temp < TEMP_SET_U);
      if (heat_r && (level == '0)) begin
        fault[FAULT_DRY_HEAT] <= 1'b1;
      end
      if (fill_en && (level == LEVEL_MAX_U)) begin
        fault[FAULT_OVERFLOW] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wash_plant.sv
// Testbench for wash_plant: a directed vector table with hand-derived
// expectations, followed by randomized command sequences checked every cycle
// against a behavioural model of the tub.
module tb_wash_plant;

  localparam int FD = 4, DD = 2, HD = 8, CD = 16;
  localparam int LMAX = 15, LFULL = 12, AMB = 10, TSET = 14, TMAX = 63;

  logic       clk = 1'b0;
  logic       reset = 1'b0, water_in = 1'b0, heat_r = 1'b0, wash = 1'b0;
  logic       drain = 1'b0, speed = 1'b0;
  logic       full, empty, cold;
  logic [7:0] level, temp;
  logic [1:0] fault;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_level = 0, m_temp = AMB, m_fault = 0;
  int m_full = 0, m_empty = 1, m_cold = 1;
  int run_f = 0, run_d = 0, run_h = 0, run_c = 0;

  typedef struct {
    logic r, w, h, d, s;
    int   n;
    int   lvl, tmp;
    logic f, e, c;
    logic [1:0] flt;
  } vec_t;

  vec_t vecs[$];

  wash_plant dut (
    .clk      (clk),
    .reset    (reset),
    .water_in (water_in),
    .heat_r   (heat_r),
    .wash     (wash),
    .drain    (drain),
    .speed    (speed),
    .full     (full),
    .empty    (empty),
    .cold     (cold),
    .level    (level),
    .temp     (temp),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, w, h, d, s, n, lvl, tmp, f, e, c, flt);
    vec_t v;
    v.r = (r != 0); v.w = (w != 0); v.h = (h != 0); v.d = (d != 0); v.s = (s != 0);
    v.n = n; v.lvl = lvl; v.tmp = tmp;
    v.f = (f != 0); v.e = (e != 0); v.c = (c != 0);
    v.flt = 2'(flt);
    return v;
  endfunction

  // Each channel: count consecutive enabled edges; every DIV-th one moves the
  // quantity. Sensors and faults look at the values held before the edge.
  task automatic model_edge(input logic r, w, h, d, s);
    int ol, ot;
    ol = m_level;
    ot = m_temp;
    if (!r) begin
      m_level = 0; m_temp = AMB; m_fault = 0;
      m_full = 0; m_empty = 1; m_cold = 1;
      run_f = 0; run_d = 0; run_h = 0; run_c = 0;
    end else begin
      run_f = (w && !d) ? run_f + 1 : 0;
      run_d = (d && !w) ? run_d + 1 : 0;
      run_h = (h && ol != 0) ? run_h + 1 : 0;
      run_c = (!h && ot > AMB) ? run_c + 1 : 0;
      if (run_f > 0 && run_f % FD == 0) m_level = (ol + 1 > LMAX) ? LMAX : ol + 1;
      if (run_d > 0 && run_d % DD == 0) m_level = (ol - (s ? 2 : 1) < 0) ? 0 : ol - (s ? 2 : 1);
      if (run_h > 0 && run_h % HD == 0) m_temp = (ot + 1 > TMAX) ? TMAX : ot + 1;
      if (run_c > 0 && run_c % CD == 0) m_temp = ot - 1;
      m_full  = (ol >= LFULL);
      m_empty = (ol == 0);
      m_cold  = (ot < TSET);
      if (h && ol == 0) m_fault = m_fault | 1;
      if (w && !d && ol == LMAX) m_fault = m_fault | 2;
    end
  endtask

  task automatic cycle(input logic r, w, h, d, s);
    reset = r; water_in = w; heat_r = h; drain = d; speed = s;
    wash = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge(r, w, h, d, s);
    #1;
  endtask

  task automatic check(input string nm, input int lvl, tmp, f, e, c, flt);
    logic [20:0] act, exp;
    act = {level, temp, full, empty, cold, fault};
    exp = {8'(lvl), 8'(tmp), 1'(f), 1'(e), 1'(c), 2'(flt)};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got level=%0d temp=%0d full=%b empty=%b cold=%b fault=%b, expected level=%0d temp=%0d full=%b empty=%b cold=%b fault=%b",
               nm, act[20:13], act[12:5], act[4], act[3], act[2], act[1:0],
               exp[20:13], exp[12:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  initial begin
    // r w h d s  n    lvl tmp f e c flt
    vecs.push_back(mk(0,0,0,0,0,  2,   0, 10, 0,1,1, 0)); // reset state
    vecs.push_back(mk(1,1,0,0,0, 48,  12, 10, 0,0,1, 0)); // fill to 12, full lags
    vecs.push_back(mk(1,1,0,0,0,  1,  12, 10, 1,0,1, 0)); // full one cycle later
    vecs.push_back(mk(1,1,0,0,0, 11,  15, 10, 1,0,1, 0)); // saturates at 15
    vecs.push_back(mk(1,1,0,0,0,  1,  15, 10, 1,0,1, 2)); // overflow fault
    vecs.push_back(mk(1,0,0,1,0, 30,   0, 10, 0,0,1, 2)); // drain 15 steps, empty lags
    vecs.push_back(mk(1,0,0,1,0,  1,   0, 10, 0,1,1, 2)); // empty one cycle later
    vecs.push_back(mk(1,0,1,0,0,  1,   0, 10, 0,1,1, 3)); // dry heat fault, temp held
    vecs.push_back(mk(1,0,0,0,0,  3,   0, 10, 0,1,1, 3)); // faults sticky
    vecs.push_back(mk(0,0,0,0,0,  1,   0, 10, 0,1,1, 0)); // reset clears faults
    vecs.push_back(mk(1,1,0,0,0, 48,  12, 10, 0,0,1, 0)); // refill to 12
    vecs.push_back(mk(1,0,1,0,0, 32,  12, 14, 1,0,1, 0)); // heat 10->14, cold lags
    vecs.push_back(mk(1,0,1,0,0,  1,  12, 14, 1,0,0, 0)); // cold drops
    vecs.push_back(mk(1,0,0,0,0, 64,  12, 10, 1,0,1, 0)); // cool back to ambient
    vecs.push_back(mk(1,0,0,0,0, 20,  12, 10, 1,0,1, 0)); // holds at ambient
    vecs.push_back(mk(1,0,0,1,1, 12,   0, 10, 0,0,1, 0)); // fast drain 12 cycles
    vecs.push_back(mk(1,0,0,1,1,  1,   0, 10, 0,1,1, 0)); // empty lags
    vecs.push_back(mk(1,1,0,0,0, 28,   7, 10, 0,0,1, 0)); // fill to 7
    vecs.push_back(mk(1,1,0,1,0, 20,   7, 10, 0,0,1, 0)); // valve+pump: hold
    vecs.push_back(mk(1,1,0,0,0,  3,   7, 10, 0,0,1, 0)); // prescaler restarted
    vecs.push_back(mk(1,1,0,0,0,  1,   8, 10, 0,0,1, 0)); // full period after hold
    vecs.push_back(mk(1,1,0,0,0, 28,  15, 10, 1,0,1, 0)); // reach 15
    vecs.push_back(mk(1,1,0,0,0,  1,  15, 10, 1,0,1, 2)); // overflow fault
    vecs.push_back(mk(0,0,0,0,0,  1,   0, 10, 0,1,1, 0)); // reset
    vecs.push_back(mk(1,1,0,0,0, 30,   7, 10, 0,0,1, 0)); // level 7, prescaler 2
    vecs.push_back(mk(0,1,0,0,0,  1,   0, 10, 0,1,1, 0)); // reset mid-fill
    vecs.push_back(mk(1,1,0,0,0,  3,   0, 10, 0,1,1, 0)); // no partial tick kept
    vecs.push_back(mk(1,1,0,0,0,  1,   1, 10, 0,1,1, 0)); // first step after 4
    vecs.push_back(mk(1,1,0,0,0,  1,   1, 10, 0,0,1, 0)); // empty lags
    vecs.push_back(mk(1,0,0,1,1,  2,   0, 10, 0,0,1, 0)); // -2 from 1 clamps to 0
    vecs.push_back(mk(1,1,0,0,0,  8,   2, 10, 0,0,1, 0)); // level 2
    vecs.push_back(mk(1,0,1,0,0,424,   2, 63, 0,0,0, 0)); // heat to ceiling
    vecs.push_back(mk(1,0,1,0,0, 16,   2, 63, 0,0,0, 0)); // saturates at 63

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        cycle(vecs[i].r, vecs[i].w, vecs[i].h, vecs[i].d, vecs[i].s);
      end
      check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].tmp,
            int'(vecs[i].f), int'(vecs[i].e), int'(vecs[i].c), int'(vecs[i].flt));
    end

    // Randomized segments against the model
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rand_reset", m_level, m_temp, m_full, m_empty, m_cold, m_fault);
    for (int seg = 0; seg < 150; seg++) begin
      logic r, w, h, d, s;
      int len;
      r = ($urandom_range(0, 39) != 0);
      w = ($urandom_range(0, 99) < 50);
      d = ($urandom_range(0, 99) < 35);
      h = ($urandom_range(0, 99) < 55);
      s = 1'($urandom_range(0, 1));
      len = r ? $urandom_range(1, 60) : 1;
      for (int k = 0; k < len; k++) begin
        cycle(r, w, h, d, s);
        check($sformatf("rand_seg%0d_c%0d", seg, k),
              m_level, m_temp, m_full, m_empty, m_cold, m_fault);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_plant.md
WASH_PLANT -- requirements
Module: wash_plant

Interface
REQ-001 Parameter FILL_DIV, 4: clock cycles per +1 water-level step while filling.
REQ-002 Parameter DRAIN_DIV, 2: clock cycles per water-level decrement step while draining.
REQ-003 Parameter HEAT_DIV, 8: clock cycles per +1 temperature step while heating.
REQ-004 Parameter COOL_DIV, 16: clock cycles per -1 temperature step while cooling.
REQ-005 Parameters LEVEL_MAX 15, LEVEL_FULL 12: tub capacity and full-sensor threshold.
REQ-006 Parameters AMBIENT 10, TEMP_SET 14, TEMP_MAX 63: resting, target and ceiling temperature.
REQ-007 clk  in  1  single system clock; all state changes on rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 water_in  in  1  inlet valve command from controller.
REQ-010 heat_r  in  1  heater command.
REQ-011 wash  in  1  drum wash command; no effect on plant state; accepted for interface completeness.
REQ-012 drain  in  1  drain pump command.
REQ-013 speed  in  1  spin command; doubles drain rate.
REQ-014 full  out  1  level >= LEVEL_FULL.
REQ-015 empty  out  1  level == 0.
REQ-016 cold  out  1  temp < TEMP_SET.
REQ-017 level  out  8  current water level, unsigned.
REQ-018 temp  out  8  current water temperature, unsigned.
REQ-019 fault  out  2  sticky faults: bit0 dry-heat, bit1 overflow.

Function
REQ-020 Each rate channel (fill, drain, heat, cool) SHALL use its own prescaler counting 0..DIV-1 while enabled, emitting a one-cycle tick when count==DIV-1, and clearing to 0 whenever disabled.
REQ-021 First tick SHALL occur DIV cycles after enable is first sampled high.
REQ-022 Fill enable = water_in & ~drain; on fill tick, level +1, saturating at LEVEL_MAX.
REQ-023 Drain enable = drain & ~water_in; on drain tick, level -1 (-2 if speed=1), saturating at 0.
REQ-024 water_in=1 and drain=1 together SHALL hold level constant and clear both prescalers.
REQ-025 Heat enable = heat_r & (level != 0); on heat tick, temp +1, saturating at TEMP_MAX.
REQ-026 Cool enable = ~heat_r & (temp > AMBIENT); on cool tick, temp -1; temp never drops below AMBIENT.
REQ-027 full, empty, cold SHALL be registered: each reflects the level/temp register value of the previous cycle (one-cycle lag after a counter change).
REQ-028 fault[0] SHALL set on the cycle after heat_r=1 is sampled with level==0; temp unchanged.
REQ-029 fault[1] SHALL set on the cycle after water_in=1 & ~drain is sampled with level==LEVEL_MAX.
REQ-030 Fault bits SHALL be sticky and cleared only by reset; they never block plant operation.

Reset
REQ-031 On any rising edge with reset=0: level=0, temp=AMBIENT, all prescalers=0, full=0, empty=1, cold=1, fault=0, regardless of inputs or operation in progress.
REQ-032 After release, counting restarts from prescaler 0; no partial tick is retained.

Structure
REQ-033 Default parameter values and fault bit indices SHALL live in a shared wash package/include used by wash_fsm and wash_plant.
REQ-034 Prescaler SHALL be one sub-module, wash_tick (params DIV; ports clk, reset, en, tick), instantiated four times.
REQ-035 Top level holds level/temp registers, sensor flops and fault logic; total RTL 120-400 lines.

Verification (default parameters)
REQ-036 Reset, then water_in=1 held -> level steps at cycles 4,8,..., reaches 12 at cycle 48; full=1 at cycle 49; stops at 15, fault[1]=1 one cycle after the next fill is attempted at 15.
REQ-037 From level 12, drain=1 -> level 0 after 24 cycles, empty=1 one cycle later; with speed=1 -> level 0 after 12 cycles.
REQ-038 Level 12, heat_r=1 -> temp 10->14 at cycle 32, cold=0 at cycle 33; heat_r=0 -> temp back to 10 after 64 cycles, then holds 10.
REQ-039 Level 0, heat_r=1 -> fault[0]=1 next cycle, temp stays 10; fault persists after heat_r=0 until reset.
REQ-040 water_in=1 and drain=1 together -> level unchanged for 20+ cycles, no ticks.
REQ-041 reset=0 mid-fill at level 7, prescaler 2 -> next edge all reset values; after release with water_in=1, first increment 4 cycles later.
